sysid_ext: RTL and testbench
============================

SYSID_EXT -- requirements
Module: sysid_ext

Interface
REQ-001 SHALL have parameter SYSTEM_ID, default 32'h5144_C0CA, value returned at word 0.
REQ-002 SHALL have parameter TIMESTAMP, default 32'd0, build timestamp returned at word 1.
REQ-003 SHALL have parameter COUNTER_W, default 64, legal range 33..64, uptime counter width.
REQ-004 SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2, cycles from read to readdatavalid.
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port address  input  3  word address.
REQ-008 SHALL have port read  input  1  read strobe, one-cycle request.
REQ-009 SHALL have port write  input  1  write strobe, one-cycle request.
REQ-010 SHALL have port writedata  input  32  write data.
REQ-011 SHALL have port byteenable  input  4  per-byte write enables.
REQ-012 SHALL have port readdata  output  32  registered read data.
REQ-013 SHALL have port readdatavalid  output  1  qualifies readdata for exactly one cycle per read.

Function
REQ-014 SHALL map words: 0 ID (RO), 1 TIMESTAMP (RO), 2 UPTIME_LO (RO), 3 UPTIME_HI_SNAP (RO), 4 SCRATCH (RW), 5 CONTROL (RW), 6 CAPS (RO), 7 reserved (reads 0).
REQ-015 SHALL increment the uptime counter by 1 each cycle while CONTROL[0] (enable) = 1; modulo 2^COUNTER_W wrap to 0.
REQ-016 SHALL return counter bits [31:0] on a UPTIME_LO read and, in that same cycle, capture bits [COUNTER_W-1:32], zero-extended, into UPTIME_HI_SNAP.
REQ-017 SHALL make UPTIME_HI_SNAP change only on UPTIME_LO reads, so LO-then-HI reads are coherent across a carry.
REQ-018 SHALL clear the counter to 0 on a write with CONTROL bit1 = 1 and byteenable[0] = 1; bit1 self-clears and always reads 0.
REQ-019 SHALL give clear priority over increment when both occur in the same cycle; counter = 0 the next cycle.
REQ-020 SHALL apply SCRATCH and CONTROL writes per byte lane under byteenable; CONTROL bits [31:2] read 0.
REQ-021 SHALL ignore writes to words 0, 1, 2, 3, 6, 7 with no side effects.
REQ-022 SHALL return CAPS = {16'h0001 version, 8'(READ_LATENCY), 8'(COUNTER_W)}.
REQ-023 SHALL present readdata and readdatavalid = 1 exactly READ_LATENCY cycles after the read cycle.
REQ-024 SHALL fully pipeline reads: back-to-back reads yield back-to-back valid cycles in order.
REQ-025 SHALL, when read and write are both asserted to the same word, return the pre-write value and commit the write.
REQ-026 SHALL hold readdata at its last value when readdatavalid = 0.

Reset
REQ-027 SHALL on reset asynchronously set counter 0, UPTIME_HI_SNAP 0, SCRATCH 0, CONTROL[0] 1, readdata 0, readdatavalid 0, and the read pipeline empty.
REQ-028 SHALL discard any in-flight read when reset is asserted; no readdatavalid after reset deassertion for a read issued before it.

Structure
REQ-029 SHALL place word-address constants, the CAPS version constant and the CONTROL bit positions in shared package sysid_ext_pkg.
REQ-030 SHALL implement the counter and snapshot in one sub-module sysid_uptime_counter; decode and read pipeline stay in sysid_ext.

Verification
REQ-031 SHALL cover: reset, then read word 0 -> readdata 32'h5144_C0CA with readdatavalid READ_LATENCY cycles later; word 6 with defaults -> 32'h0001_0140.
REQ-032 SHALL cover: force counter to 64'h0000_0000_FFFF_FFFE, read LO then HI 3 cycles later -> LO 32'hFFFF_FFFE, HI 0 (snapshot, not live 1).
REQ-033 SHALL cover: write SCRATCH 32'hDEAD_BEEF with byteenable 4'b0101 from 0 -> read 32'h00AD_00EF.
REQ-034 SHALL cover: write CONTROL 32'h2 -> counter 0 next cycle, enable cleared to 0, CONTROL reads 0, counter stays 0 for 10 cycles.
REQ-035 SHALL cover: COUNTER_W=33 at 33'h1_FFFF_FFFF enabled -> wraps to 0 next cycle; read of word 3 after LO read -> 1 captured before wrap if read in the wrap cycle.
REQ-036 SHALL cover: four back-to-back reads of words 0,1,4,7 with READ_LATENCY=2, reset asserted during the third -> only the first two return valid data.

Source files
------------

// File: rtl/sysid_ext_pkg.sv
// -----------------------------------------------------------------------------
// sysid_ext_pkg
// Shared definitions for the system-ID / uptime register block:
//   - word_e        : word addresses of the 8-entry register map
//   - CAPS_VERSION  : version field returned in the upper half of CAPS
//   - CTRL_*_BIT    : bit positions inside the CONTROL word
//   - merge_bytes() : byte-lane write merge used by the RW registers
//   - caps_word()   : assembles the CAPS word from the build parameters
// -----------------------------------------------------------------------------
package sysid_ext_pkg;

  typedef enum logic [2:0] {
    WORD_ID        = 3'd0,
    WORD_TIMESTAMP = 3'd1,
    WORD_UPTIME_LO = 3'd2,
    WORD_UPTIME_HI = 3'd3,
    WORD_SCRATCH   = 3'd4,
    WORD_CONTROL   = 3'd5,
    WORD_CAPS      = 3'd6,
    WORD_RESERVED  = 3'd7
  } word_e;

  localparam logic [15:0] CAPS_VERSION = 16'h0001;

  // CONTROL[0] enables counting, CONTROL[1] is a write-only clear strobe.
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CLEAR_BIT  = 1;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lane_en);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) begin
        result[i*8 +: 8] = new_word[i*8 +: 8];
      end
    end
    return result;
  endfunction

  function automatic logic [31:0] caps_word(input int read_latency,
                                            input int counter_w);
    return {CAPS_VERSION, 8'(read_latency), 8'(counter_w)};
  endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// -----------------------------------------------------------------------------
// sysid_uptime_counter
// Free-running uptime counter with a coherent high-word snapshot.
//   clock        : sole clock, rising edge
//   reset        : asynchronous, active-high; clears counter and snapshot
//   enable       : count by one each cycle while high
//   clear        : synchronous clear; wins over enable in the same cycle
//   snap_capture : high in the cycle UPTIME_LO is read; latches the upper bits
//   count_lo     : live counter bits [31:0]
//   snap_hi      : latched counter bits [COUNTER_W-1:32], zero-extended
// -----------------------------------------------------------------------------
module sysid_uptime_counter #(
  parameter int COUNTER_W = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic        snap_capture,
  output logic [31:0] count_lo,
  output logic [31:0] snap_hi
);

  localparam logic [COUNTER_W-1:0] COUNT_ONE = COUNTER_W'(1);

  logic [COUNTER_W-1:0] count_reg;
  logic [31:0]          snap_reg;

  // The addition wraps naturally at 2^COUNTER_W.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + COUNT_ONE;
    end
  end

  // The snapshot samples the same pre-increment value that the LO read
  // returns, so a LO-then-HI read pair is consistent across a carry out
  // of bit 31 regardless of how many cycles separate the two reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_reg <= '0;
    end else if (snap_capture) begin
      snap_reg <= 32'(count_reg[COUNTER_W-1:32]);
    end
  end

  assign count_lo = count_reg[31:0];
  assign snap_hi  = snap_reg;

endmodule

// File: rtl/sysid_ext.sv
// -----------------------------------------------------------------------------
// sysid_ext
// Eight-word memory-mapped identification block: system ID, build timestamp,
// uptime counter (LO live, HI snapshot), scratch register, control register
// and a capabilities word. Reads are pipelined with a fixed latency.
//   clock         : sole clock, rising edge
//   reset         : asynchronous, active-high
//   address[2:0]  : word address
//   read          : one-cycle read request
//   write         : one-cycle write request
//   writedata     : write data
//   byteenable    : per-byte write enables
//   readdata      : registered read data, held while readdatavalid is low
//   readdatavalid : one pulse per read, READ_LATENCY cycles after the request
// -----------------------------------------------------------------------------
module sysid_ext
  import sysid_ext_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID    = 32'h5144_C0CA,
  parameter logic [31:0] TIMESTAMP    = 32'd0,
  parameter int          COUNTER_W    = 64,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  if (COUNTER_W < 33 || COUNTER_W > 64) begin : g_bad_counter_w
    $error("sysid_ext: COUNTER_W must be in 33..64");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_read_latency
    $error("sysid_ext: READ_LATENCY must be 1 or 2");
  end

  localparam logic [31:0] CAPS_VALUE = caps_word(READ_LATENCY, COUNTER_W);

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  logic wr_scratch;
  logic wr_control;
  logic ctrl_lane0;
  logic clear_pulse;
  logic snap_capture;

  assign wr_scratch   = write && (address == WORD_SCRATCH);
  assign wr_control   = write && (address == WORD_CONTROL);
  assign ctrl_lane0   = wr_control && byteenable[0];
  // The clear bit is never stored; it only produces this one-cycle strobe,
  // which is why CONTROL[1] always reads back as zero.
  assign clear_pulse  = ctrl_lane0 && writedata[CTRL_CLEAR_BIT];
  assign snap_capture = read && (address == WORD_UPTIME_LO);

  logic [31:0] scratch_reg;
  logic        enable_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch_reg <= '0;
    end else if (wr_scratch) begin
      scratch_reg <= merge_bytes(scratch_reg, writedata, byteenable);
    end
  end

  // Counting is on out of reset so uptime starts without software help.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable_reg <= 1'b1;
    end else if (ctrl_lane0) begin
      enable_reg <= writedata[CTRL_ENABLE_BIT];
    end
  end

  // ---------------------------------------------------------------------------
  // Uptime counter and snapshot
  // ---------------------------------------------------------------------------
  logic [31:0] count_lo;
  logic [31:0] snap_hi;

  sysid_uptime_counter #(
    .COUNTER_W (COUNTER_W)
  ) u_uptime (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable_reg),
    .clear        (clear_pulse),
    .snap_capture (snap_capture),
    .count_lo     (count_lo),
    .snap_hi      (snap_hi)
  );

  // ---------------------------------------------------------------------------
  // Read mux: sampled from current register state, so a read that coincides
  // with a write to the same word returns the value before that write.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    case (word_e'(address))
      WORD_ID:        rd_word = SYSTEM_ID;
      WORD_TIMESTAMP: rd_word = TIMESTAMP;
      WORD_UPTIME_LO: rd_word = count_lo;
      WORD_UPTIME_HI: rd_word = snap_hi;
      WORD_SCRATCH:   rd_word = scratch_reg;
      WORD_CONTROL:   rd_word[CTRL_ENABLE_BIT] = enable_reg;
      WORD_CAPS:      rd_word = CAPS_VALUE;
      default:        rd_word = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: one stage per cycle of latency, last stage drives the
  // outputs. A stage's data only moves when its incoming valid is set, so the
  // final stage holds the last returned word between reads. Reset empties
  // every stage, discarding anything in flight.
  // ---------------------------------------------------------------------------
  logic [READ_LATENCY-1:0]       stage_valid_reg;
  logic [READ_LATENCY-1:0][31:0] stage_data_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_valid_reg <= '0;
      stage_data_reg  <= '0;
    end else begin
      stage_valid_reg[0] <= read;
      if (read) begin
        stage_data_reg[0] <= rd_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_valid_reg[i] <= stage_valid_reg[i-1];
        if (stage_valid_reg[i-1]) begin
          stage_data_reg[i] <= stage_data_reg[i-1];
        end
      end
    end
  end

  assign readdata      = stage_data_reg[READ_LATENCY-1];
  assign readdatavalid = stage_valid_reg[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_ext.sv
// -----------------------------------------------------------------------------
// tb_sysid_ext
// Two instances: dut0 with default parameters (64-bit counter, latency 1)
// and dut1 with a 33-bit counter and latency 2. dut0 is tracked by a
// register-level model; dut1 is driven by hand-written sequences with
// constant expectations. Every cycle both read ports are checked against a
// queue of expected returns: a valid pulse with the right data on the due
// cycle, otherwise no valid and readdata holding its last value.
// -----------------------------------------------------------------------------
module tb_sysid_ext;

  localparam logic [31:0] TS1 = 32'h2024_0611;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_0, read_0, write_0, readdatavalid_0;
  logic [2:0]  address_0;
  logic [31:0] writedata_0, readdata_0;
  logic [3:0]  byteenable_0;

  logic        reset_1, read_1, write_1, readdatavalid_1;
  logic [2:0]  address_1;
  logic [31:0] writedata_1, readdata_1;
  logic [3:0]  byteenable_1;

  sysid_ext dut0 (
    .clock         (clock),
    .reset         (reset_0),
    .address       (address_0),
    .read          (read_0),
    .write         (write_0),
    .writedata     (writedata_0),
    .byteenable    (byteenable_0),
    .readdata      (readdata_0),
    .readdatavalid (readdatavalid_0)
  );

  sysid_ext #(
    .TIMESTAMP    (TS1),
    .COUNTER_W    (33),
    .READ_LATENCY (2)
  ) dut1 (
    .clock         (clock),
    .reset         (reset_1),
    .address       (address_1),
    .read          (read_1),
    .write         (write_1),
    .writedata     (writedata_1),
    .byteenable    (byteenable_1),
    .readdata      (readdata_1),
    .readdatavalid (readdatavalid_1)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last0 = 32'd0;
  logic [31:0] last1 = 32'd0;

  // dut0 reference state
  logic [63:0] m_count;
  logic [31:0] m_snap;
  logic [31:0] m_scratch;
  logic        m_enable;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'h5144_C0CA;
      3'd1:    return 32'd0;
      3'd2:    return m_count[31:0];
      3'd3:    return m_snap;
      3'd4:    return m_scratch;
      3'd5:    return {31'd0, m_enable};
      3'd6:    return 32'h0001_0140;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_count   = 64'd0;
    m_snap    = 32'd0;
    m_scratch = 32'd0;
    m_enable  = 1'b1;
  endtask

  task automatic model_update();
    logic clr;
    if (read_0 && address_0 == 3'd2) m_snap = m_count[63:32];
    clr = write_0 && address_0 == 3'd5 && byteenable_0[0] && writedata_0[1];
    if (clr) m_count = 64'd0;
    else if (m_enable) m_count = m_count + 64'd1;
    if (write_0 && address_0 == 3'd4)
      for (int b = 0; b < 4; b++)
        if (byteenable_0[b]) m_scratch[b*8 +: 8] = writedata_0[b*8 +: 8];
    if (write_0 && address_0 == 3'd5 && byteenable_0[0]) m_enable = writedata_0[0];
  endtask

  task automatic check_port(input int id, input logic v, input logic [31:0] d);
    exp_t e;
    logic due_now;
    if (id == 0) due_now = (q0.size() > 0) && (q0[0].due == cyc);
    else         due_now = (q1.size() > 0) && (q1[0].due == cyc);
    if (due_now) begin
      if (id == 0) e = q0.pop_front(); else e = q1.pop_front();
      chk($sformatf("dut%0d_valid", id), {31'd0, v}, 32'd1);
      chk($sformatf("dut%0d_data", id), d, e.data);
      if (id == 0) last0 = e.data; else last1 = e.data;
    end else begin
      chk($sformatf("dut%0d_novalid", id), {31'd0, v}, 32'd0);
      chk($sformatf("dut%0d_hold", id), d, (id == 0) ? last0 : last1);
    end
  endtask

  // One clock: model dut0 on the current inputs, clock, then check both ports.
  task automatic step();
    if (reset_0) begin
      model_reset();
    end else begin
      if (read_0) q0.push_back('{cyc + 1, model_read(address_0)});
      model_update();
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    check_port(0, readdatavalid_0, readdata_0);
    check_port(1, readdatavalid_1, readdata_1);
  endtask

  task automatic drive0(input logic rd, input logic wr, input logic [2:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    read_0 = rd; write_0 = wr; address_0 = a; writedata_0 = wd; byteenable_0 = be;
  endtask

  task automatic rd1(input logic [2:0] a, input logic [31:0] req);
    read_1 = 1'b1; address_1 = a;
    q1.push_back('{cyc + 2, req});
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 32'h0,         4'h0, 32'h5144_C0CA};
    tbl[1]  = '{1'b1, 1'b0, 3'd1, 32'h0,         4'h0, 32'h0000_0000};
    tbl[2]  = '{1'b1, 1'b0, 3'd6, 32'h0,         4'h0, 32'h0001_0140};
    tbl[3]  = '{1'b1, 1'b0, 3'd7, 32'h0,         4'h0, 32'h0000_0000};
    tbl[4]  = '{1'b1, 1'b0, 3'd4, 32'h0,         4'h0, 32'h0000_0000};
    tbl[5]  = '{1'b0, 1'b1, 3'd4, 32'hDEAD_BEEF, 4'h5, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 3'd4, 32'h0,         4'h0, 32'h00AD_00EF};
    tbl[7]  = '{1'b0, 1'b1, 3'd4, 32'h1234_5678, 4'hA, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 3'd4, 32'h0,         4'h0, 32'h12AD_56EF};
    tbl[9]  = '{1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 3'd0, 32'h0,         4'h0, 32'h5144_C0CA};
    tbl[11] = '{1'b1, 1'b0, 3'd5, 32'h0,         4'h0, 32'h0000_0001};
    tbl[12] = '{1'b0, 1'b1, 3'd5, 32'hFFFF_FFFF, 4'hE, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 3'd5, 32'h0,         4'h0, 32'h0000_0001};
    tbl[14] = '{1'b1, 1'b1, 3'd4, 32'h0,         4'hF, 32'h12AD_56EF};
    tbl[15] = '{1'b1, 1'b0, 3'd4, 32'h0,         4'h0, 32'h0000_0000};

    reset_0 = 1'b1; reset_1 = 1'b1;
    drive0(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    read_1 = 1'b0; write_1 = 1'b0; address_1 = 3'd0; writedata_1 = 32'd0; byteenable_1 = 4'd0;
    model_reset();
    @(negedge clock);
    repeat (3) step();
    chk("reset_rdv0", {31'd0, readdatavalid_0}, 32'd0);
    chk("reset_data0", readdata_0, 32'd0);
    chk("reset_rdv1", {31'd0, readdatavalid_1}, 32'd0);
    chk("reset_data1", readdata_1, 32'd0);
    reset_0 = 1'b0; reset_1 = 1'b0;
    step();

    // Table-driven register map checks on dut0 (latency 1).
    for (int i = 0; i < 16; i++) begin
      drive0(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be);
      step();
      if (tbl[i].rd) chk($sformatf("tbl%0d", i), readdata_0, tbl[i].exp_rd);
    end
    drive0(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    step();

    // Clear with enable off: counter zero next cycle and stays there.
    drive0(1'b0, 1'b1, 3'd5, 32'h0000_0002, 4'hF); step();
    drive0(1'b1, 1'b0, 3'd2, 32'd0, 4'd0);         step();
    chk("clear_next", readdata_0, 32'd0);
    drive0(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    repeat (10) step();
    drive0(1'b1, 1'b0, 3'd2, 32'd0, 4'd0); step();
    chk("clear_hold", readdata_0, 32'd0);
    drive0(1'b1, 1'b0, 3'd5, 32'd0, 4'd0); step();
    chk("ctrl_after_clear", readdata_0, 32'd0);

    // Clear beats increment while enabled.
    drive0(1'b0, 1'b1, 3'd5, 32'h0000_0001, 4'h1); step();
    drive0(1'b0, 1'b1, 3'd5, 32'h0000_0003, 4'h1); step();
    drive0(1'b1, 1'b0, 3'd2, 32'd0, 4'd0);         step();
    chk("clr_prio_0", readdata_0, 32'd0);
    step();
    chk("clr_prio_1", readdata_0, 32'd1);

    // LO/HI coherence across a carry out of bit 31.
    drive0(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    force dut0.u_uptime.count_reg = 64'h0000_0000_FFFF_FFFE;
    step();
    release dut0.u_uptime.count_reg;
    m_count = 64'h0000_0000_FFFF_FFFE;
    drive0(1'b1, 1'b0, 3'd2, 32'd0, 4'd0); step();
    chk("coh_lo", readdata_0, 32'hFFFF_FFFE);
    drive0(1'b0, 1'b0, 3'd0, 32'd0, 4'd0); step(); step();
    drive0(1'b1, 1'b0, 3'd3, 32'd0, 4'd0); step();
    chk("coh_hi_snap", readdata_0, 32'h0000_0000);
    drive0(1'b1, 1'b0, 3'd2, 32'd0, 4'd0); step();
    chk("coh_lo2", readdata_0, 32'h0000_0002);
    drive0(1'b1, 1'b0, 3'd3, 32'd0, 4'd0); step();
    chk("coh_hi2", readdata_0, 32'h0000_0001);
    drive0(1'b0, 1'b0, 3'd0, 32'd0, 4'd0); step();

    // dut1: ID and CAPS with latency 2.
    rd1(3'd0, 32'h5144_C0CA); step();
    rd1(3'd6, 32'h0001_0221); step();
    read_1 = 1'b0; step(); step();

    // dut1: 33-bit wrap, snapshot taken in the wrap cycle.
    force dut1.u_uptime.count_reg = 33'h1_FFFF_FFFF;
    step();
    release dut1.u_uptime.count_reg;
    rd1(3'd2, 32'hFFFF_FFFF); step();
    rd1(3'd3, 32'h0000_0001); step();
    rd1(3'd2, 32'h0000_0001); step();
    rd1(3'd3, 32'h0000_0000); step();
    read_1 = 1'b0; step(); step(); step();

    // dut1: back-to-back reads, reset lands while the third is in flight.
    rd1(3'd0, 32'h5144_C0CA); step();
    rd1(3'd1, TS1);           step();
    read_1 = 1'b1; address_1 = 3'd4; step();
    reset_1 = 1'b1; address_1 = 3'd7;
    q1.delete();
    last1 = 32'd0;
    #1;
    chk("inflight_rst_valid", {31'd0, readdatavalid_1}, 32'd0);
    step();
    read_1 = 1'b0;
    step();
    reset_1 = 1'b0;
    repeat (5) step();

    // Randomised traffic on dut0 against the model.
    for (int n = 0; n < 400; n++) begin
      drive0(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
      step();
    end
    drive0(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    step(); step();

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
